// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit direction counters.
//
// Lookup is combinational (zero latency); updates, allocation, flush and reset
// take effect on the rising edge of clk.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   pc_i                     fetch PC looked up this cycle
//   pre_hit_o/taken_o/target_o  prediction for pc_i
//   set_i, set_pc_i, set_taken_i, set_target_i, set_error_i
//                            resolved-branch update
//   flush_i                  invalidate every entry
//   stat_update_o, stat_alloc_o, stat_error_o
//                            32-bit wrapping event counters; present only
//                            when the macro BTB_STATS_EN is defined
//
// Index = pc[SETW+1:2], tag = pc[SETW+TAGW+1:SETW+2]. WAYS may be 1, 2 or 4.
module btb_assoc #(
    parameter int unsigned SETW = 6,
    parameter int unsigned WAYS = 2,
    parameter int unsigned TAGW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pre_hit_o,
    output logic        pre_taken_o,
    output logic [31:0] pre_target_o,
    input  logic        set_i,
    input  logic [31:0] set_pc_i,
    input  logic        set_taken_i,
    input  logic [31:0] set_target_i,
    input  logic        set_error_i,
    input  logic        flush_i
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] stat_update_o,
    output logic [31:0] stat_alloc_o,
    output logic [31:0] stat_error_o
`endif
);
    localparam int unsigned SETS = 1 << SETW;
    localparam int unsigned PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic            valid_q  [SETS][WAYS];
    logic [TAGW-1:0] tag_q    [SETS][WAYS];
    logic [31:0]     target_q [SETS][WAYS];
    logic [1:0]      cnt_q    [SETS][WAYS];
    logic [PW-1:0]   rr_q     [SETS];

    logic [SETW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [SETW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic [31:0]     pc_plus4;

    assign lk_idx   = pc_i[SETW+1:2];
    assign lk_tag   = pc_i[SETW+TAGW+1:SETW+2];
    assign up_idx   = set_pc_i[SETW+1:2];
    assign up_tag   = set_pc_i[SETW+TAGW+1:SETW+2];
    assign pc_plus4 = pc_i + 32'd4;

    // Lookup with same-cycle bypass from the update port.
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        bypass;

    always_comb begin
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = pc_plus4;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit    = 1'b1;
                lk_taken  = cnt_q[lk_idx][w][1];
                lk_target = target_q[lk_idx][w];
            end
        end
        bypass = set_i && !flush_i && (set_pc_i == pc_i);
        if (bypass) begin
            pre_hit_o    = 1'b1;
            pre_taken_o  = set_taken_i;
            pre_target_o = set_taken_i ? set_target_i : pc_plus4;
        end else begin
            pre_hit_o    = lk_hit;
            pre_taken_o  = lk_taken;
            pre_target_o = lk_target;
        end
    end

    // Update-side way selection and counter arithmetic.
    logic          up_hit;
    logic [PW-1:0] up_way;
    logic          has_free;
    logic [PW-1:0] free_way;
    logic [PW-1:0] victim;
    logic [PW-1:0] rr_nxt;
    logic [1:0]    cnt_cur;
    logic [1:0]    cnt_nxt;
    logic          alloc;

    always_comb begin
        up_hit   = 1'b0;
        up_way   = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = PW'(w);
            end
            if (!valid_q[up_idx][w] && !has_free) begin
                has_free = 1'b1;
                free_way = PW'(w);
            end
        end
        if (WAYS == 1) begin
            victim = '0;
            rr_nxt = '0;
        end else begin
            victim = has_free ? free_way : rr_q[up_idx];
            rr_nxt = (rr_q[up_idx] == PW'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;
        end
        cnt_cur = cnt_q[up_idx][up_way];
        if (set_error_i) begin
            cnt_nxt = set_taken_i ? 2'b10 : 2'b01;
        end else if (set_taken_i) begin
            cnt_nxt = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
        end else begin
            cnt_nxt = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'd1;
        end
        alloc = set_i && !up_hit && set_taken_i;
    end

    // Tags and targets are deliberately left out of the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    cnt_q[s][w]   <= 2'b00;
                end
            end
        end else if (flush_i) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (set_i) begin
            if (up_hit) begin
                cnt_q[up_idx][up_way] <= cnt_nxt;
                if (set_taken_i) begin
                    target_q[up_idx][up_way] <= set_target_i;
                end
            end else if (alloc) begin
                valid_q[up_idx][victim]  <= 1'b1;
                tag_q[up_idx][victim]    <= up_tag;
                target_q[up_idx][victim] <= set_target_i;
                cnt_q[up_idx][victim]    <= 2'b10;
                // The pointer moves only when it actually chose the victim.
                if ((WAYS > 1) && !has_free) begin
                    rr_q[up_idx] <= rr_nxt;
                end
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_update_o <= '0;
            stat_alloc_o  <= '0;
            stat_error_o  <= '0;
        end else if (set_i && !flush_i) begin
            stat_update_o <= stat_update_o + 32'd1;
            if (set_error_i) begin
                stat_error_o <= stat_error_o + 32'd1;
            end
            if (alloc) begin
                stat_alloc_o <= stat_alloc_o + 32'd1;
            end
        end
    end
`endif

endmodule
